// File: rtl/clk_step_ctrl.sv
// ----------------------------------------------------------------------------
// clk_step_ctrl
//
// Single-step / free-run clock-enable controller for a hobby processor.
// A prescaler divides clkin down to a periodic tick. A small FSM decides
// whether that tick reaches the processor: continuously (RUN), once per
// debounced button press (STEP), or not at all (HALT).
//
// Parameters
//   DIV_W     width of the prescaler divide value
//   DB_MAX    number of consecutive stable clkin cycles the synchronized
//             pushbutton must differ from its debounced level before that
//             level is updated
//
// Ports
//   clkin     in   1      system clock
//   rst       in   1      asynchronous, active-high reset
//   run_req   in   1      asynchronous level requesting free-run mode
//   step_btn  in   1      asynchronous bouncy pushbutton, one step per press
//   halt_req  in   1      synchronous level forcing HALT (overrides requests)
//   div_val   in   DIV_W  prescaler period in clkin cycles (0 and 1 = every cycle)
//   cpu_en    out  1      one-clkin-cycle processor clock-enable pulse
//   clkout    out  1      toggles after each cpu_en pulse, for an LED or scope
//   state     out  2      FSM state: 00 HALT, 01 RUN, 10 STEP
//   instr_cnt out  16     count of cpu_en pulses, wraps 0xFFFF -> 0x0000
//
// Configuration
//   CLK_STEP_INSTR_CNT_EN  when defined, instr_cnt is a live 16-bit counter;
//                          when undefined, instr_cnt is tied to 16'h0000 and
//                          no counter flops exist.
// ----------------------------------------------------------------------------
module clk_step_ctrl #(
    parameter int unsigned DIV_W  = 24,
    parameter int unsigned DB_MAX = 1000000
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             cpu_en,
    output logic             clkout,
    output logic [1:0]       state,
    output logic [15:0]      instr_cnt
);

    // ------------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------------
    // Debounce counter runs 0..DB_MAX-1, so $clog2(DB_MAX) bits is enough.
    localparam int unsigned DB_W    = (DB_MAX > 1) ? $clog2(DB_MAX) : 1;
    localparam int unsigned DB_LASTI = (DB_MAX > 0) ? (DB_MAX - 1) : 0;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_LASTI);

    typedef enum logic [1:0] {
        StHalt = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10
    } state_e;

    // ------------------------------------------------------------------------
    // Input synchronizers (two flops each)
    // ------------------------------------------------------------------------
    logic run_meta;
    logic run_sync;
    logic step_meta;
    logic step_sync;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            run_meta  <= 1'b0;
            run_sync  <= 1'b0;
            step_meta <= 1'b0;
            step_sync <= 1'b0;
        end else begin
            run_meta  <= run_req;
            run_sync  <= run_meta;
            step_meta <= step_btn;
            step_sync <= step_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Pushbutton debounce
    // ------------------------------------------------------------------------
    // db_level follows step_sync only once the two have disagreed for DB_MAX
    // consecutive cycles; any cycle of agreement clears the run length.
    logic [DB_W-1:0] db_cnt;
    logic            db_level;
    logic            db_prev;
    logic            step_pulse;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            db_prev <= db_level;
            if (step_sync != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= step_sync;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Rising edge of the debounced level: high for exactly one cycle.
    assign step_pulse = db_level & ~db_prev;

    // ------------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] pre_cnt;
    logic [DIV_W-1:0] div_last;
    logic             div_short;
    logic             tick;

    assign div_last  = div_val - 1'b1;
    assign div_short = (div_val <= DIV_W'(1));
    // div_last underflows for div_val == 0, but div_short masks that case.
    assign tick      = div_short | (pre_cnt == div_last);

    // A count already past the new terminal value (div_val lowered mid-count)
    // wraps without producing a tick, since pre_cnt != div_last there.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (div_short || (pre_cnt >= div_last)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Run / step / halt FSM
    // ------------------------------------------------------------------------
    state_e st_q;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            st_q <= StHalt;
        end else begin
            case (st_q)
                StHalt: begin
                    // step_pulse is only consumed here; elsewhere it is dropped.
                    if (!halt_req) begin
                        if (run_sync) begin
                            st_q <= StRun;
                        end else if (step_pulse) begin
                            st_q <= StStep;
                        end
                    end
                end
                StRun: begin
                    if (halt_req || !run_sync) begin
                        st_q <= StHalt;
                    end
                end
                StStep: begin
                    // Either the single enabled tick has gone out, or a halt
                    // cancelled the step before it did.
                    if (halt_req || tick) begin
                        st_q <= StHalt;
                    end
                end
                default: st_q <= StHalt;
            endcase
        end
    end

    assign state = st_q;

    // cpu_en is decoded from the registered state in the same cycle as tick so
    // the pulse lines up with the prescaler and is suppressed in the very
    // cycle a halt or run drop is seen. Reset forces state to HALT, which
    // clears cpu_en immediately.
    always_comb begin
        cpu_en = 1'b0;
        case (st_q)
            StRun:   cpu_en = tick & ~halt_req & run_sync;
            StStep:  cpu_en = tick & ~halt_req;
            default: cpu_en = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Visible clock and instruction counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            clkout <= 1'b0;
        end else if (cpu_en) begin
            clkout <= ~clkout;
        end
    end

`ifdef CLK_STEP_INSTR_CNT_EN
    logic [15:0] icnt;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            icnt <= 16'h0000;
        end else if (cpu_en) begin
            icnt <= icnt + 16'd1;
        end
    end

    assign instr_cnt = icnt;
`else
    assign instr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_step_ctrl
//
// Directed scenarios with hand-computed pulse cycles. Stimulus pushes each
// expected cpu_en pulse (cycle, instr_cnt, clkout) into a queue; a monitor on
// the falling edge pops and compares whenever cpu_en is high.
// ----------------------------------------------------------------------------
module tb_clk_step_ctrl;

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned DB_MAX = 4;

    logic             clkin    = 1'b0;
    logic             rst      = 1'b0;
    logic             run_req  = 1'b0;
    logic             step_btn = 1'b0;
    logic             halt_req = 1'b0;
    logic [DIV_W-1:0] div_val  = '0;
    logic             cpu_en;
    logic             clkout;
    logic [1:0]       state;
    logic [15:0]      instr_cnt;

    clk_step_ctrl #(
        .DIV_W  (DIV_W),
        .DB_MAX (DB_MAX)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .run_req   (run_req),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .div_val   (div_val),
        .cpu_en    (cpu_en),
        .clkout    (clkout),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] cnt;
        logic        clk;
    } exp_t;

    exp_t sb_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   model_n     = 0;
    int   base        = 0;
    bit   sb_on       = 1'b1;
    int   bulk_pulses = 0;

    function automatic logic [15:0] exp_cnt(input int n);
        logic [15:0] v;
        v = n[15:0];
`ifndef CLK_STEP_INSTR_CNT_EN
        v = 16'h0000;
`endif
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int c);
        exp_t e;
        e.cyc = c;
        e.cnt = exp_cnt(model_n);
        e.clk = model_n[0];
        sb_q.push_back(e);
        model_n++;
    endtask

    task automatic wait_cyc(input int x);
        while (cyc < x) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic sample_at(input int x);
        wait_cyc(x);
        @(negedge clkin);
    endtask

    task automatic do_reset();
        @(posedge clkin);
        #1;
        rst = 1'b1;
        #2;
        check("rst_state", int'(state), 0);
        check("rst_cpu_en", int'(cpu_en), 0);
        check("rst_clkout", int'(clkout), 0);
        check("rst_instr_cnt", int'(instr_cnt), 0);
        @(posedge clkin);
        #1;
        rst     = 1'b0;
        base    = cyc;
        model_n = 0;
    endtask

    // Scoreboard monitor
    always @(negedge clkin) begin
        exp_t e;
        if (!rst && cpu_en) begin
            if (!sb_on) begin
                bulk_pulses++;
            end else if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cpu_en: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_instr_cnt", int'(instr_cnt), int'(e.cnt));
                check("pulse_clkout", int'(clkout), int'(e.clk));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Free run, div 3: RUN after sync, pulse every 3rd cycle, clean exit.
        do_reset();
        div_val = 8'd3;
        run_req = 1'b1;
        push_exp(base + 5);
        push_exp(base + 8);
        push_exp(base + 11);
        sample_at(base + 2);
        check("run_sync_wait_state", int'(state), 0);
        sample_at(base + 3);
        check("run_state", int'(state), 1);
        wait_cyc(base + 12);
        run_req = 1'b0;
        sample_at(base + 14);
        check("run_drop_no_en", int'(cpu_en), 0);
        sample_at(base + 15);
        check("run_drop_state", int'(state), 0);
        check("run_instr_cnt", int'(instr_cnt), int'(exp_cnt(3)));
        wait_cyc(base + 20);
        check("run_sb_drained", sb_q.size(), 0);

        // Bouncy button: 1-0-1 each 2 cycles, then high 6 cycles -> one step.
        do_reset();
        div_val  = 8'd3;
        step_btn = 1'b1;
        push_exp(base + 11);
        wait_cyc(base + 2);
        step_btn = 1'b0;
        wait_cyc(base + 4);
        step_btn = 1'b1;
        sample_at(base + 10);
        check("step_pre_state", int'(state), 0);
        step_btn = 1'b0;
        sample_at(base + 11);
        check("step_state", int'(state), 2);
        sample_at(base + 12);
        check("step_back_halt", int'(state), 0);
        wait_cyc(base + 25);
        check("step_sb_drained", sb_q.size(), 0);
        check("step_final_state", int'(state), 0);

        // Halt asserted in a tick cycle, div 5.
        do_reset();
        div_val = 8'd5;
        run_req = 1'b1;
        push_exp(base + 4);
        push_exp(base + 9);
        wait_cyc(base + 14);
        halt_req = 1'b1;
        run_req  = 1'b0;
        sample_at(base + 14);
        check("halt_tick_no_en", int'(cpu_en), 0);
        sample_at(base + 15);
        check("halt_state", int'(state), 0);
        wait_cyc(base + 16);
        halt_req = 1'b0;
        wait_cyc(base + 22);
        check("halt_sb_drained", sb_q.size(), 0);
        check("halt_final_state", int'(state), 0);

        // div_val lowered below the running count: wrap, no tick.
        do_reset();
        div_val = 8'd10;
        run_req = 1'b1;
        push_exp(base + 10);
        push_exp(base + 14);
        wait_cyc(base + 6);
        div_val = 8'd4;
        sample_at(base + 6);
        check("div_shrink_no_en", int'(cpu_en), 0);
        wait_cyc(base + 15);
        halt_req = 1'b1;
        run_req  = 1'b0;
        wait_cyc(base + 17);
        halt_req = 1'b0;
        wait_cyc(base + 22);
        check("div_shrink_sb_drained", sb_q.size(), 0);

        // div_val 0: cpu_en every cycle, clkout toggles every cycle.
        do_reset();
        div_val = 8'd0;
        run_req = 1'b1;
        for (int k = 3; k <= 10; k++) push_exp(base + k);
        wait_cyc(base + 11);
        halt_req = 1'b1;
        run_req  = 1'b0;
        sample_at(base + 12);
        check("div0_halt_state", int'(state), 0);
        wait_cyc(base + 13);
        halt_req = 1'b0;
        wait_cyc(base + 18);
        check("div0_sb_drained", sb_q.size(), 0);
        check("div0_clkout", int'(clkout), 0);
        check("div0_instr_cnt", int'(instr_cnt), int'(exp_cnt(8)));

        // Reset between edges in the middle of a STEP (div 1 run first).
        do_reset();
        div_val = 8'd1;
        run_req = 1'b1;
        push_exp(base + 3);
        push_exp(base + 4);
        push_exp(base + 5);
        wait_cyc(base + 6);
        halt_req = 1'b1;
        run_req  = 1'b0;
        wait_cyc(base + 8);
        halt_req = 1'b0;
        div_val  = 8'd20;
        step_btn = 1'b1;
        sample_at(base + 16);
        check("mid_step_state", int'(state), 2);
        check("mid_step_clkout", int'(clkout), 1);
        check("mid_step_instr_cnt", int'(instr_cnt), int'(exp_cnt(3)));
        wait_cyc(base + 20);
        #2;
        rst      = 1'b1;
        step_btn = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_cpu_en", int'(cpu_en), 0);
        check("async_rst_clkout", int'(clkout), 0);
        check("async_rst_instr_cnt", int'(instr_cnt), 0);
        model_n = 0;
        @(posedge clkin);
        @(posedge clkin);
        #3;
        rst  = 1'b0;
        base = cyc;
        wait_cyc(base + 40);
        check("after_rst_state", int'(state), 0);
        check("after_rst_sb_drained", sb_q.size(), 0);

        // 65536 pulses: instr_cnt reaches 0xFFFF then wraps to 0x0000.
        do_reset();
        div_val     = 8'd0;
        run_req     = 1'b1;
        sb_on       = 1'b0;
        bulk_pulses = 0;
        sample_at(base + 65538);
        check("wrap_last_en", int'(cpu_en), 1);
        check("wrap_ffff", int'(instr_cnt), int'(exp_cnt(65535)));
        wait_cyc(base + 65539);
        halt_req = 1'b1;
        run_req  = 1'b0;
        @(negedge clkin);
        check("wrap_halt_no_en", int'(cpu_en), 0);
        check("wrap_zero", int'(instr_cnt), int'(exp_cnt(65536)));
        check("wrap_clkout", int'(clkout), 0);
        check("wrap_pulse_total", bulk_pulses, 65536);
        wait_cyc(base + 65541);
        halt_req = 1'b0;
        sb_on    = 1'b1;
        wait_cyc(base + 65546);
        check("wrap_final_state", int'(state), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
